approx_adder_error_monitor: RTL and testbench

//  Downstream consumer of the 16-bit approximate adder: accepts operand pairs plus the approximate 17-bit sum,

---
 rtl/approx_adder_error_monitor.sv | 190 +++++++++++++++++++
 tb/tb_approx_adder_error_monitor.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/approx_adder_error_monitor.sv
// approx_adder_error_monitor
// Consumes operand pairs plus the approximate adder's 17-bit result, recomputes
// the exact sum and accumulates error metrics over a programmed sample count.
// Two-stage datapath: stage 1 captures exact/approx on accept, stage 2 forms
// |exact - approx| and folds it into the metrics on the following edge.
// Optional feature macro: ERRMON_SQERR_EN adds a saturating sum_sq_err output.
module approx_adder_error_monitor #(
  parameter int OP_W  = 16,
  parameter int CNT_W = 32,
  parameter int ACC_W = 48
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [CNT_W-1:0]   num_samples,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [OP_W-1:0]    op_a,
  input  logic [OP_W-1:0]    op_b,
  input  logic [OP_W:0]      approx_sum,
  output logic               busy,
  output logic               done,
  output logic [CNT_W-1:0]   sample_cnt,
  output logic [CNT_W-1:0]   err_cnt,
  output logic [OP_W:0]      max_abs_err,
  output logic [ACC_W-1:0]   sum_abs_err
`ifdef ERRMON_SQERR_EN
  ,
  output logic [2*ACC_W-1:0] sum_sq_err
`endif
);

  localparam int SQ_W = 2 * (OP_W + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] target_q, target_d;
  logic [CNT_W-1:0] sample_cnt_q, sample_cnt_d;
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
  logic [OP_W:0]    max_abs_err_q, max_abs_err_d;
  logic [ACC_W-1:0] sum_abs_err_q, sum_abs_err_d;
  logic             s1_valid_q, s1_valid_d;
  logic [OP_W:0]    exact_q, exact_d;
  logic [OP_W:0]    approx_q, approx_d;
`ifdef ERRMON_SQERR_EN
  logic [2*ACC_W-1:0] sum_sq_err_q, sum_sq_err_d;
  logic [SQ_W-1:0]    sq_term;
  logic [2*ACC_W:0]   sq_ext;
  logic [2*ACC_W-1:0] sq_sat;
`endif

  logic             start_run;
  logic             accept;
  logic             last_accept;
  logic [OP_W:0]    abs_err;
  logic [ACC_W:0]   sum_ext;
  logic [ACC_W-1:0] sum_sat;

  // Control decodes shared by the FSM and the datapath.
  assign start_run   = start && ((state_q == S_IDLE) || (state_q == S_DONE));
  assign accept      = in_valid && in_ready;
  assign last_accept = accept && ((sample_cnt_q + CNT_W'(1)) == target_q);

  // FSM next state and status outputs decoded from the registered state.
  always_comb begin
    state_d  = state_q;
    in_ready = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    case (state_q)
      S_IDLE, S_DONE: begin
        done = (state_q == S_DONE);
        if (start) state_d = (num_samples == '0) ? S_DONE : S_RUN;
      end
      S_RUN: begin
        busy     = 1'b1;
        in_ready = (sample_cnt_q != target_q);
        if (last_accept) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        busy = 1'b1;
        if (!s1_valid_q) state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Stage-2 arithmetic: unsigned distance between exact and approx, and the
  // saturating accumulator candidates.
  always_comb begin
    abs_err = (exact_q >= approx_q) ? (exact_q - approx_q) : (approx_q - exact_q);
    sum_ext = {1'b0, sum_abs_err_q} + {{(ACC_W - OP_W){1'b0}}, abs_err};
    sum_sat = sum_ext[ACC_W] ? {ACC_W{1'b1}} : sum_ext[ACC_W-1:0];
`ifdef ERRMON_SQERR_EN
    sq_term = {{(OP_W + 1){1'b0}}, abs_err} * {{(OP_W + 1){1'b0}}, abs_err};
    sq_ext  = {1'b0, sum_sq_err_q} + {{(2 * ACC_W + 1 - SQ_W){1'b0}}, sq_term};
    sq_sat  = sq_ext[2*ACC_W] ? {(2 * ACC_W){1'b1}} : sq_ext[2*ACC_W-1:0];
`endif
  end

  // Datapath next state: run setup, accept counting, stage-1 capture, metric update.
  always_comb begin
    target_d      = target_q;
    sample_cnt_d  = sample_cnt_q;
    err_cnt_d     = err_cnt_q;
    max_abs_err_d = max_abs_err_q;
    sum_abs_err_d = sum_abs_err_q;
`ifdef ERRMON_SQERR_EN
    sum_sq_err_d  = sum_sq_err_q;
`endif
    s1_valid_d    = accept;
    exact_d       = exact_q;
    approx_d      = approx_q;
    if (accept) begin
      exact_d  = {1'b0, op_a} + {1'b0, op_b};
      approx_d = approx_sum;
    end
    if (start_run) begin
      // No beat can be in flight in IDLE/DONE, so clearing here loses nothing.
      target_d      = num_samples;
      sample_cnt_d  = '0;
      err_cnt_d     = '0;
      max_abs_err_d = '0;
      sum_abs_err_d = '0;
`ifdef ERRMON_SQERR_EN
      sum_sq_err_d  = '0;
`endif
    end else begin
      if (accept) sample_cnt_d = sample_cnt_q + CNT_W'(1);
      if (s1_valid_q) begin
        err_cnt_d     = err_cnt_q + CNT_W'(abs_err != '0);
        max_abs_err_d = (abs_err > max_abs_err_q) ? abs_err : max_abs_err_q;
        sum_abs_err_d = sum_sat;
`ifdef ERRMON_SQERR_EN
        sum_sq_err_d  = sq_sat;
`endif
      end
    end
  end

  // Datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      target_q      <= '0;
      sample_cnt_q  <= '0;
      err_cnt_q     <= '0;
      max_abs_err_q <= '0;
      sum_abs_err_q <= '0;
`ifdef ERRMON_SQERR_EN
      sum_sq_err_q  <= '0;
`endif
      s1_valid_q    <= 1'b0;
      exact_q       <= '0;
      approx_q      <= '0;
    end else begin
      target_q      <= target_d;
      sample_cnt_q  <= sample_cnt_d;
      err_cnt_q     <= err_cnt_d;
      max_abs_err_q <= max_abs_err_d;
      sum_abs_err_q <= sum_abs_err_d;
`ifdef ERRMON_SQERR_EN
      sum_sq_err_q  <= sum_sq_err_d;
`endif
      s1_valid_q    <= s1_valid_d;
      exact_q       <= exact_d;
      approx_q      <= approx_d;
    end
  end

  assign sample_cnt  = sample_cnt_q;
  assign err_cnt     = err_cnt_q;
  assign max_abs_err = max_abs_err_q;
  assign sum_abs_err = sum_abs_err_q;
`ifdef ERRMON_SQERR_EN
  assign sum_sq_err  = sum_sq_err_q;
`endif

endmodule

// File: tb/tb_approx_adder_error_monitor.sv
// Bench for approx_adder_error_monitor: directed runs plus randomized runs,
// each checked against an arithmetic reference computed from the beat list.
module tb_approx_adder_error_monitor;
  localparam int OP_W  = 16;
  localparam int CNT_W = 32;
  localparam int ACC_W = 48;

  logic               clk = 1'b0;
  logic               rst;
  logic               start;
  logic [CNT_W-1:0]   num_samples;
  logic               in_valid;
  logic               in_ready;
  logic [OP_W-1:0]    op_a;
  logic [OP_W-1:0]    op_b;
  logic [OP_W:0]      approx_sum;
  logic               busy;
  logic               done;
  logic [CNT_W-1:0]   sample_cnt;
  logic [CNT_W-1:0]   err_cnt;
  logic [OP_W:0]      max_abs_err;
  logic [ACC_W-1:0]   sum_abs_err;
`ifdef ERRMON_SQERR_EN
  logic [2*ACC_W-1:0] sum_sq_err;
`endif

  int checks = 0;
  int errors = 0;

  logic [OP_W-1:0] qa[$];
  logic [OP_W-1:0] qb[$];
  logic [OP_W:0]   qs[$];

  approx_adder_error_monitor #(.OP_W(OP_W), .CNT_W(CNT_W), .ACC_W(ACC_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .num_samples (num_samples),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .op_a        (op_a),
    .op_b        (op_b),
    .approx_sum  (approx_sum),
    .busy        (busy),
    .done        (done),
    .sample_cnt  (sample_cnt),
    .err_cnt     (err_cnt),
    .max_abs_err (max_abs_err),
    .sum_abs_err (sum_abs_err)
`ifdef ERRMON_SQERR_EN
    ,
    .sum_sq_err  (sum_sq_err)
`endif
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ready"}, 128'(in_ready), 128'(0));
    check({tag, "_busy"},  128'(busy), 128'(0));
    check({tag, "_done"},  128'(done), 128'(0));
    check({tag, "_scnt"},  128'(sample_cnt), 128'(0));
    check({tag, "_ecnt"},  128'(err_cnt), 128'(0));
    check({tag, "_max"},   128'(max_abs_err), 128'(0));
    check({tag, "_sum"},   128'(sum_abs_err), 128'(0));
`ifdef ERRMON_SQERR_EN
    check({tag, "_sq"},    128'(sum_sq_err), 128'(0));
`endif
  endtask

  task automatic push(input int a, input int b, input int s);
    qa.push_back(OP_W'(a));
    qb.push_back(OP_W'(b));
    qs.push_back((OP_W + 1)'(s));
  endtask

  // Random beat: approx is exact, slightly low, slightly high, or arbitrary.
  task automatic push_random();
    int a, b, ex, ap, off;
    a   = int'($urandom_range(0, 65535));
    b   = int'($urandom_range(0, 65535));
    ex  = a + b;
    off = int'($urandom_range(1, 40));
    case ($urandom_range(0, 3))
      0: ap = ex;
      1: begin ap = ex - off; if (ap < 0) ap = 0; end
      2: begin ap = ex + off; if (ap > 131071) ap = 131071; end
      default: ap = int'($urandom_range(0, 131071));
    endcase
    push(a, b, ap);
  endtask

  // Run one job over the queued beats; gaps follow the valid pattern 1,0,0,1,1.
  task automatic run_beats(input int n, input bit use_gaps, input bit poke, input string tag);
    int      idx, cyc, pat_i, ex, d, exp_cnt, exp_max;
    longint  exp_sum, exp_sq;
    bit      v;
    bit      pat[5];
    pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    exp_cnt = 0; exp_max = 0; exp_sum = 0; exp_sq = 0;
    for (int i = 0; i < n; i++) begin
      ex = int'(qa[i]) + int'(qb[i]);
      d  = ex - int'(qs[i]);
      if (d < 0) d = -d;
      if (d != 0) exp_cnt++;
      if (d > exp_max) exp_max = d;
      exp_sum += longint'(d);
      exp_sq  += longint'(d) * longint'(d);
    end

    start = 1'b1; num_samples = CNT_W'(n); in_valid = 1'b0;
    step();
    start = 1'b0;
    if (n == 0) begin
      check({tag, "_zdone"},  128'(done), 128'(1));
      check({tag, "_zready"}, 128'(in_ready), 128'(0));
      check({tag, "_zbusy"},  128'(busy), 128'(0));
      check({tag, "_zscnt"},  128'(sample_cnt), 128'(0));
      check({tag, "_zsum"},   128'(sum_abs_err), 128'(0));
      check({tag, "_zmax"},   128'(max_abs_err), 128'(0));
      check({tag, "_zecnt"},  128'(err_cnt), 128'(0));
      step();
      check({tag, "_zready2"}, 128'(in_ready), 128'(0));
      check({tag, "_zdone2"},  128'(done), 128'(1));
      $display("run %s n=0 done=%0d samples=%0d", tag, done, sample_cnt);
      return;
    end
    check({tag, "_busy0"}, 128'(busy), 128'(1));
    check({tag, "_done0"}, 128'(done), 128'(0));
    check({tag, "_scnt0"}, 128'(sample_cnt), 128'(0));

    idx = 0; cyc = 0; pat_i = 0;
    while (idx < n && cyc < 2000) begin
      v = use_gaps ? pat[pat_i % 5] : 1'b1;
      pat_i++;
      in_valid = v;
      if (v) begin
        op_a = qa[idx]; op_b = qb[idx]; approx_sum = qs[idx];
      end else begin
        op_a = OP_W'($urandom); op_b = OP_W'($urandom); approx_sum = (OP_W + 1)'($urandom);
      end
      start       = poke && (cyc == 1);
      num_samples = poke ? CNT_W'(n + 3) : CNT_W'(n);
      check({tag, "_ready"}, 128'(in_ready), 128'(1));
      step();
      cyc++;
      if (v) idx++;
      check({tag, "_scnt"}, 128'(sample_cnt), 128'(idx));
    end
    check({tag, "_beats"}, 128'(idx), 128'(n));

    // Hold in_valid high after the last accept: nothing more may be taken.
    start = 1'b0; in_valid = 1'b1;
    check({tag, "_rdylow"}, 128'(in_ready), 128'(0));
    check({tag, "_done1"},  128'(done), 128'(0));
    step();
    in_valid = 1'b0;
    check({tag, "_done2"},   128'(done), 128'(0));
    check({tag, "_noextra"}, 128'(sample_cnt), 128'(n));
    step();
    check({tag, "_done3"}, 128'(done), 128'(1));
    check({tag, "_busy3"}, 128'(busy), 128'(0));
    check({tag, "_ecnt"},  128'(err_cnt), 128'(exp_cnt));
    check({tag, "_max"},   128'(max_abs_err), 128'(exp_max));
    check({tag, "_sum"},   128'(sum_abs_err), 128'(exp_sum));
`ifdef ERRMON_SQERR_EN
    check({tag, "_sq"},    128'(sum_sq_err), 128'(exp_sq));
`endif
    $display("run %s n=%0d samples=%0d errs=%0d max=%0d sum=%0d", tag, n, sample_cnt,
             err_cnt, max_abs_err, sum_abs_err);
    qa.delete(); qb.delete(); qs.delete();
  endtask

  // Four beats with errors 5, 0, 12 and 3 (the last has approx above exact).
  task automatic push_err_set();
    push(100, 50, 145);
    push(10, 20, 30);
    push(1000, 1, 989);
    push(7, 8, 18);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; num_samples = '0; in_valid = 1'b0;
    op_a = '0; op_b = '0; approx_sum = '0;
    step();
    step();
    check_all_zero("reset");
    @(negedge clk);
    rst = 1'b0;
    step();
    check_all_zero("idle");

    push(16'h0003, 16'h0005, 17'h00008);
    run_beats(1, 1'b0, 1'b0, "exact1");

    push(16'h07FF, 16'h0001, 17'h00000);
    run_beats(1, 1'b0, 1'b0, "err800");

    push_err_set();
    run_beats(4, 1'b0, 1'b0, "b2b4");

    run_beats(0, 1'b0, 1'b0, "zero");

    // Reset in the middle of an 8-beat run after two accepted beats.
    for (int i = 0; i < 8; i++) push_random();
    start = 1'b1; num_samples = CNT_W'(8);
    step();
    start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1; op_a = qa[i]; op_b = qb[i]; approx_sum = (OP_W + 1)'(int'(qs[i]) ^ 1);
      step();
    end
    in_valid = 1'b0;
    check("midrun_scnt", 128'(sample_cnt), 128'(2));
    #2 rst = 1'b1;
    #1;
    check_all_zero("asyncrst");
    step();
    @(negedge clk);
    rst = 1'b0;
    step();
    check_all_zero("postrst");
    qa.delete(); qb.delete(); qs.delete();
    push_random();
    push_random();
    run_beats(2, 1'b0, 1'b0, "afterrst");

    push_err_set();
    run_beats(4, 1'b1, 1'b1, "gappoke");

    for (int r = 0; r < 4; r++) begin
      int n;
      n = int'($urandom_range(5, 24));
      for (int i = 0; i < n; i++) push_random();
      run_beats(n, r[0], r[1], $sformatf("rand%0d", r));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
